// File: rtl/decoder2x4_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module : decoder_pkg
// Desc   : Shared types and widths for the 2-to-4 pulse decoder.
// Rev    : 1.0
// ============================================================================
package decoder_pkg;

  localparam int CODE_W   = 2;
  localparam int ONEHOT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/decoder2x4_pulse_if.sv
`default_nettype none
// ============================================================================
// Module : decoder2x4_pulse_if
// Desc   : Code input handshake and decoded output bundle.
// Rev    : 1.0
// ============================================================================
interface decoder2x4_pulse_if #(
  parameter int HOLD_W = 4,
  parameter int DEPTH  = 4
);
  import decoder_pkg::*;

  logic [CODE_W-1:0]        in;
  logic                     in_valid;
  logic                     in_ready;
  logic [HOLD_W-1:0]        hold;
  logic [ONEHOT_W-1:0]      result;
  logic                     out_active;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output in, in_valid, hold,
    input  in_ready, result, out_active, level
  );

  modport slave (
    input  in, in_valid, hold,
    output in_ready, result, out_active, level
  );

endinterface
`default_nettype wire

// File: rtl/decoder2x4_pulse_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Desc   : Single-clock FIFO with occupancy count; head is visible on rdata_o.
// Rev    : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [LVL_W-1:0] level_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rptr_q];
  assign level_o   = level_q;

  always_ff @(posedge clk) begin
    if (!rst && w_do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (w_do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (w_do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/decoder2x4_pulse.sv
`default_nettype none
// ============================================================================
// Module : decoder2x4_pulse
// Desc   : Buffered 2-to-4 decoder emitting hold+1 cycle one-hot pulses.
// Rev    : 1.0
// ============================================================================
module decoder2x4_pulse #(
  parameter int HOLD_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder2x4_pulse_if.slave    bus
);
  import decoder_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  dec_state_t            state_q, state_d;
  logic [ONEHOT_W-1:0]   result_q, result_d;
  logic [HOLD_W-1:0]     cnt_q, cnt_d;
  logic                  active_q;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic [CODE_W-1:0]     w_head;
  logic [LVL_W-1:0]      w_level;

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .pop_i   (w_pop),
    .wdata_i (bus.in),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  assign bus.in_ready   = !w_full;
  assign bus.result     = result_q;
  assign bus.out_active = active_q;
  assign bus.level      = w_level;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    w_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        result_d = '0;
        if (!w_empty) begin
          w_pop    = 1'b1;
          result_d = {{(ONEHOT_W-1){1'b0}}, 1'b1} << w_head;
          cnt_d    = bus.hold;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          result_d = '0;
          state_d  = GAP;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      GAP: begin
        result_d = '0;
        state_d  = IDLE;
      end
      default: begin
        result_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      active_q <= (state_d == DRIVE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder2x4_pulse.sv
`default_nettype none
// ============================================================================
// Module : tb_decoder2x4_pulse
// Desc   : Directed, table-driven bench for decoder2x4_pulse.
// Rev    : 1.0
// ============================================================================
module tb_decoder2x4_pulse;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic mon_en;

  decoder2x4_pulse_if #(.HOLD_W(4), .DEPTH(4)) dif();

  decoder2x4_pulse #(.HOLD_W(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] code;
    logic [3:0] hold;
    logic [3:0] exp_res;
    int         exp_w;
  } vec_t;

  typedef struct {
    logic [3:0] val;
    int         width;
    int         gap;
  } pulse_t;

  pulse_t     pq[$];
  logic [3:0] cur_val;
  int         cur_len;
  int         cur_gap;
  int         zeros;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle invariants plus run-length capture of every output pulse.
  always @(negedge clk) begin
    if (!mon_en) begin
      cur_len = 0;
      zeros   = 0;
    end else begin
      chk("level_bound", (dif.level <= 4), 1);
      chk("ready_vs_level", dif.in_ready, (dif.level != 4));
      chk("active_vs_result", dif.out_active, (dif.result != 4'b0));
      chk("result_onehot0", $onehot0(dif.result), 1);
      if (dif.result != 4'b0) begin
        if (cur_len == 0) begin
          cur_val = dif.result; cur_gap = zeros; zeros = 0; cur_len = 1;
        end else if (dif.result == cur_val) begin
          cur_len++;
        end else begin
          pq.push_back('{cur_val, cur_len, cur_gap});
          cur_val = dif.result; cur_gap = 0; cur_len = 1;
        end
      end else begin
        if (cur_len > 0) begin
          pq.push_back('{cur_val, cur_len, cur_gap});
          cur_len = 0;
        end
        zeros++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] c);
    int t;
    t = 0;
    dif.in       = c;
    dif.in_valid = 1'b1;
    while (!dif.in_ready && t < 100) begin
      tick();
      t++;
    end
    chk("push_wait_expired", (t >= 100), 0);
    tick();
    dif.in_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int base, input int n);
    int t;
    t = 0;
    while (pq.size() < base + n && t < 500) begin
      tick();
      t++;
    end
    chk("pulse_count", pq.size() - base, n);
  endtask

  vec_t       vecs[6];
  logic [3:0] burst_exp[5];
  logic [1:0] wrap_codes[10];
  int         base;

  initial begin
    vecs[0] = '{2'd0, 4'd0, 4'b0001, 1};
    vecs[1] = '{2'd1, 4'd0, 4'b0010, 1};
    vecs[2] = '{2'd2, 4'd0, 4'b0100, 1};
    vecs[3] = '{2'd3, 4'd0, 4'b1000, 1};
    vecs[4] = '{2'd2, 4'd3, 4'b0100, 4};
    vecs[5] = '{2'd1, 4'd1, 4'b0010, 2};
    burst_exp = '{4'b1000, 4'b1000, 4'b0010, 4'b0001, 4'b0100};
    wrap_codes = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};

    checks = 0; errors = 0; mon_en = 1'b0;
    rst = 1'b1; dif.in = '0; dif.in_valid = 1'b0; dif.hold = '0;
    tick(); tick();
    chk("rst_result", dif.result, 4'b0);
    chk("rst_active", dif.out_active, 0);
    chk("rst_level", dif.level, 0);
    chk("rst_ready", dif.in_ready, 1);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single codes into an idle block, checked cycle by cycle.
    for (int v = 0; v < 6; v++) begin
      dif.hold = vecs[v].hold;
      push(vecs[v].code);
      chk("vec_level_after_push", dif.level, 1);
      chk("vec_result_before_pop", dif.result, 4'b0);
      for (int w = 0; w < vecs[v].exp_w; w++) begin
        tick();
        chk("vec_result_drive", dif.result, vecs[v].exp_res);
        chk("vec_active_drive", dif.out_active, 1);
      end
      for (int g = 0; g < 2; g++) begin
        tick();
        chk("vec_result_gap", dif.result, 4'b0);
        chk("vec_active_gap", dif.out_active, 0);
      end
      chk("vec_level_end", dif.level, 0);
    end

    // Burst into the FIFO with hold = 5.
    base = pq.size();
    dif.hold = 4'd5;
    push(2'd3); push(2'd3); push(2'd1); push(2'd0); push(2'd2);
    chk("burst_level_full", dif.level, 4);
    chk("burst_ready_low", dif.in_ready, 0);
    tick();
    chk("burst_level_held", dif.level, 4);
    chk("burst_ready_held", dif.in_ready, 0);
    wait_pulses(base, 5);
    for (int i = 0; i < 5 && base + i < pq.size(); i++) begin
      chk("burst_val", pq[base+i].val, burst_exp[i]);
      chk("burst_width", pq[base+i].width, 6);
      if (i > 0) chk("burst_gap", pq[base+i].gap, 2);
    end
    repeat (3) tick();
    chk("burst_level_end", dif.level, 0);

    // Ten codes in bursts of three with pauses: pointers wrap twice.
    base = pq.size();
    dif.hold = 4'd0;
    for (int i = 0; i < 10; i++) begin
      push(wrap_codes[i]);
      if (i % 3 == 2) repeat (5) tick();
    end
    wait_pulses(base, 10);
    for (int i = 0; i < 10 && base + i < pq.size(); i++) begin
      chk("wrap_val", pq[base+i].val, 4'b0001 << wrap_codes[i]);
      chk("wrap_width", pq[base+i].width, 1);
      if (i > 0) chk("wrap_gap_min", (pq[base+i].gap >= 2), 1);
    end
    repeat (3) tick();

    // Reset during DRIVE with two codes queued; in_valid high during reset.
    mon_en = 1'b0;
    dif.hold = 4'd7;
    push(2'd1); push(2'd3); push(2'd0);
    chk("mid_pre_level", dif.level, 2);
    chk("mid_pre_result", dif.result, 4'b0010);
    chk("mid_pre_active", dif.out_active, 1);
    rst = 1'b1; dif.in = 2'd2; dif.in_valid = 1'b1;
    tick();
    rst = 1'b0; dif.in_valid = 1'b0;
    chk("mid_rst_result", dif.result, 4'b0);
    chk("mid_rst_active", dif.out_active, 0);
    chk("mid_rst_level", dif.level, 0);
    chk("mid_rst_ready", dif.in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mid_no_stale_result", dif.result, 4'b0);
      chk("mid_no_stale_level", dif.level, 0);
    end
    mon_en = 1'b1;
    tick();

    // Hold lowered while the first pulse is already driving.
    base = pq.size();
    dif.hold = 4'd2;
    push(2'd3); push(2'd1);
    dif.hold = 4'd0;
    wait_pulses(base, 2);
    if (pq.size() >= base + 2) begin
      chk("hold_chg_val0", pq[base].val, 4'b1000);
      chk("hold_chg_width0", pq[base].width, 3);
      chk("hold_chg_val1", pq[base+1].val, 4'b0010);
      chk("hold_chg_width1", pq[base+1].width, 1);
    end
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
